// File: rtl/mem_sel_reg_ser_p.sv
// mem_sel_reg_ser_p: serially loaded instruction/data module+sector select register with arbitrated one-hot selects.
// Optional MEMSEL_PARITY_EN: frame carries a trailing odd-parity bit, errors latch PERR.
module mem_sel_reg_ser_p #(
  parameter int MOD_W  = 2,
  parameter int SECT_W = 4
) (
  input  logic                  SIM_CLK,
  input  logic                  SIM_RST,
  input  logic                  BIT,
  input  logic                  SER_D,
  input  logic                  LD_I,
  input  logic                  LD_D,
  input  logic                  LD_ABORT,
  input  logic                  SEL_STB,
  input  logic                  ACC_I,
  input  logic                  ACC_D,
  output logic [2**MOD_W-1:0]   MSEL_N,
  output logic [SECT_W-1:0]     SECT,
  output logic                  SEL_CH,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  CONFLICT,
  output logic                  PERR
);
  localparam int NMOD = 2**MOD_W;
  localparam int RW   = SECT_W + MOD_W + 1;
`ifdef MEMSEL_PARITY_EN
  localparam int FL = RW + 1;
`else
  localparam int FL = RW;
`endif
  localparam int CW = $clog2(FL + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic [FL-1:0]     sh;
  logic              ch;
  logic [RW-1:0]     i_reg, d_reg, svc;
  logic              pend, par_ok, svc_i, svc_d;
  logic [MOD_W-1:0]  mod;
  logic [NMOD-1:0]   sel_mask;

`ifdef MEMSEL_PARITY_EN
  assign par_ok = ^sh;
  always_ff @(posedge SIM_CLK or negedge SIM_RST)
    if (!SIM_RST) PERR <= 1'b0;
    else if (state == COMMIT && !par_ok) PERR <= 1'b1;
`else
  assign par_ok = 1'b1;
  assign PERR   = 1'b0;
`endif

  always_ff @(posedge SIM_CLK or negedge SIM_RST)
    if (!SIM_RST) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state == IDLE  ? ((LD_I || LD_D) ? SHIFT : IDLE)
             : state == SHIFT ? (LD_ABORT ? IDLE : (BIT && cnt == CW'(FL - 1)) ? COMMIT : SHIFT)
             : IDLE;
  end

  always_comb begin
    BUSY = state != IDLE;
    DONE = state == COMMIT && par_ok;
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST)
    if (!SIM_RST) begin
      cnt   <= '0;
      sh    <= '0;
      ch    <= 1'b0;
      i_reg <= '0;
      d_reg <= '0;
    end else begin
      if (state == IDLE) begin
        cnt <= '0;
        ch  <= !LD_I;
      end
      if (state == SHIFT && BIT) begin
        sh  <= {SER_D, sh[FL-1:1]};
        cnt <= cnt + 1'b1;
      end
      if (state == COMMIT && par_ok && ch) d_reg <= sh[RW-1:0];
      if (state == COMMIT && par_ok && !ch) i_reg <= sh[RW-1:0];
    end

  // Instruction always wins; data is serviced only on a strobe free of ACC_I.
  assign svc_i = SEL_STB && ACC_I;
  assign svc_d = SEL_STB && !ACC_I && (ACC_D || pend);
  assign svc   = svc_i ? i_reg : d_reg;
  assign mod   = svc[SECT_W +: MOD_W];

  always_comb begin
    sel_mask = '0;
    sel_mask[mod] = 1'b1;
    if (svc[RW-1]) begin
      sel_mask[mod & ~MOD_W'(1)] = 1'b1;
      sel_mask[mod | MOD_W'(1)]  = 1'b1;
    end
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST)
    if (!SIM_RST) begin
      MSEL_N   <= '1;
      SECT     <= '0;
      SEL_CH   <= 1'b0;
      CONFLICT <= 1'b0;
      pend     <= 1'b0;
    end else begin
      MSEL_N   <= (svc_i || svc_d) ? ~sel_mask : '1;
      CONFLICT <= SEL_STB && ACC_I && ACC_D;
      if (svc_i || svc_d) begin
        SECT   <= svc[SECT_W-1:0];
        SEL_CH <= svc_d;
      end
      if (SEL_STB) pend <= ACC_I && (pend || ACC_D);
    end
endmodule

// File: tb/tb_mem_sel_reg_ser_p.sv
// tb_mem_sel_reg_ser_p: directed checks of loading, arbitration, duplex decode, abort and reset.
module tb_mem_sel_reg_ser_p;
  logic clk = 1'b0, rst_n = 1'b0;
  logic bit_s = 0, ser_d = 0, ld_i = 0, ld_d = 0, ld_abort = 0, sel_stb = 0, acc_i = 0, acc_d = 0;
  logic [3:0] msel_n, sect;
  logic sel_ch, busy, done, conflict, perr;
  int nv = 0, nerr = 0;
  logic dc, da, ba;

  mem_sel_reg_ser_p #(.MOD_W(2), .SECT_W(4)) dut (
    .SIM_CLK(clk), .SIM_RST(rst_n), .BIT(bit_s), .SER_D(ser_d), .LD_I(ld_i), .LD_D(ld_d),
    .LD_ABORT(ld_abort), .SEL_STB(sel_stb), .ACC_I(acc_i), .ACC_D(acc_d), .MSEL_N(msel_n),
    .SECT(sect), .SEL_CH(sel_ch), .BUSY(busy), .DONE(done), .CONFLICT(conflict), .PERR(perr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic i, input logic d);
    sel_stb = 1; acc_i = i; acc_d = d;
    tick();
    sel_stb = 0; acc_i = 0; acc_d = 0;
  endtask

  // ch: 0 instruction, 1 data, 2 both; coll drives an instruction access on the commit edge
  task automatic send_frame(input logic [1:0] ch, input logic [3:0] s, input logic [1:0] m,
                            input logic dup, input logic bad, input logic coll,
                            output logic done_c, output logic done_a, output logic busy_a);
    logic [7:0] fb;
    int nb;
    fb[6:0] = {dup, m, s};
    fb[7] = ~(^fb[6:0]) ^ bad;
`ifdef MEMSEL_PARITY_EN
    nb = 8;
`else
    nb = 7;
`endif
    ld_i = ch != 2'd1; ld_d = ch != 2'd0;
    tick();
    ld_i = 0; ld_d = 0;
    for (int k = 0; k < nb; k++) begin
      bit_s = 1; ser_d = fb[k];
      tick();
      bit_s = 0; ser_d = 0;
      if (k != nb - 1) tick();
    end
    done_c = done;
    if (coll) begin sel_stb = 1; acc_i = 1; end
    tick();
    sel_stb = 0; acc_i = 0;
    done_a = done; busy_a = busy;
  endtask

  task automatic test_reset;
    rst_n = 0;
    tick(); tick();
    nv++; if (msel_n !== 4'b1111) begin nerr++; $display("FAIL rst_msel got %b want 1111", msel_n); end
    nv++; if ({sect, sel_ch, busy, done, conflict, perr} !== 9'b0) begin nerr++; $display("FAIL rst_outs got %b want 0", {sect, sel_ch, busy, done, conflict, perr}); end
    rst_n = 1;
    tick();
    access(1, 0);
    nv++; if (msel_n !== 4'b1110) begin nerr++; $display("FAIL dflt_msel got %b want 1110", msel_n); end
    nv++; if (sect !== 4'd0 || sel_ch !== 1'b0) begin nerr++; $display("FAIL dflt_sect got %0d/%b want 0/0", sect, sel_ch); end
    tick();
    nv++; if (msel_n !== 4'b1111) begin nerr++; $display("FAIL sel_width got %b want 1111", msel_n); end
  endtask

  task automatic test_data_load;
    ld_i = 0; ld_d = 1;
    tick();
    nv++; if (busy !== 1'b1) begin nerr++; $display("FAIL busy_start got %b want 1", busy); end
    ld_d = 0;
    // restart the load properly via the frame helper after reset of state via abort
    ld_abort = 1; tick(); ld_abort = 0;
    send_frame(2'd1, 4'd5, 2'd2, 1'b0, 1'b0, 1'b0, dc, da, ba);
    nv++; if (dc !== 1'b1) begin nerr++; $display("FAIL done_pulse got %b want 1", dc); end
    nv++; if (da !== 1'b0 || ba !== 1'b0) begin nerr++; $display("FAIL done_end got %b%b want 00", da, ba); end
    access(0, 1);
    nv++; if (msel_n !== 4'b1011) begin nerr++; $display("FAIL d_msel got %b want 1011", msel_n); end
    nv++; if (sect !== 4'd5 || sel_ch !== 1'b1) begin nerr++; $display("FAIL d_sect got %0d/%b want 5/1", sect, sel_ch); end
  endtask

  task automatic test_duplex_conflict;
    send_frame(2'd0, 4'd9, 2'd3, 1'b1, 1'b0, 1'b0, dc, da, ba);
    nv++; if (dc !== 1'b1) begin nerr++; $display("FAIL i_done got %b want 1", dc); end
    access(1, 0);
    nv++; if (msel_n !== 4'b0011 || sect !== 4'd9 || sel_ch !== 1'b0) begin nerr++; $display("FAIL dup_sel got %b/%0d/%b want 0011/9/0", msel_n, sect, sel_ch); end
    access(1, 1);
    nv++; if (conflict !== 1'b1 || msel_n !== 4'b0011 || sel_ch !== 1'b0) begin nerr++; $display("FAIL conflict got %b/%b/%b want 1/0011/0", conflict, msel_n, sel_ch); end
    access(0, 0);
    nv++; if (conflict !== 1'b0 || msel_n !== 4'b1011 || sel_ch !== 1'b1 || sect !== 4'd5) begin nerr++; $display("FAIL deferred got %b/%b/%b/%0d want 0/1011/1/5", conflict, msel_n, sel_ch, sect); end
    access(0, 0);
    nv++; if (msel_n !== 4'b1111) begin nerr++; $display("FAIL idle_stb got %b want 1111", msel_n); end
  endtask

  task automatic test_pending;
    access(1, 1);
    access(1, 0);
    nv++; if (sel_ch !== 1'b0 || conflict !== 1'b0 || msel_n !== 4'b0011) begin nerr++; $display("FAIL pend_hold got %b/%b/%b want 0/0/0011", sel_ch, conflict, msel_n); end
    access(0, 0);
    nv++; if (sel_ch !== 1'b1 || msel_n !== 4'b1011) begin nerr++; $display("FAIL pend_svc got %b/%b want 1/1011", sel_ch, msel_n); end
    access(1, 1);
    access(0, 1);
    nv++; if (sel_ch !== 1'b1 || msel_n !== 4'b1011) begin nerr++; $display("FAIL merge got %b/%b want 1/1011", sel_ch, msel_n); end
    access(0, 0);
    nv++; if (msel_n !== 4'b1111) begin nerr++; $display("FAIL merge_once got %b want 1111", msel_n); end
  endtask

  task automatic test_commit_collision;
    send_frame(2'd0, 4'd12, 2'd1, 1'b0, 1'b0, 1'b1, dc, da, ba);
    nv++; if (msel_n !== 4'b0011 || sect !== 4'd9) begin nerr++; $display("FAIL coll_old got %b/%0d want 0011/9", msel_n, sect); end
    access(1, 0);
    nv++; if (msel_n !== 4'b1101 || sect !== 4'd12) begin nerr++; $display("FAIL coll_new got %b/%0d want 1101/12", msel_n, sect); end
  endtask

  task automatic test_ld_both;
    send_frame(2'd2, 4'd3, 2'd0, 1'b1, 1'b0, 1'b0, dc, da, ba);
    access(1, 0);
    nv++; if (msel_n !== 4'b1100 || sect !== 4'd3) begin nerr++; $display("FAIL both_i got %b/%0d want 1100/3", msel_n, sect); end
    access(0, 1);
    nv++; if (msel_n !== 4'b1011 || sect !== 4'd5) begin nerr++; $display("FAIL both_d got %b/%0d want 1011/5", msel_n, sect); end
  endtask

  task automatic test_abort;
    logic seen;
    seen = 0;
    ld_i = 1; tick(); ld_i = 0;
    for (int k = 0; k < 3; k++) begin
      bit_s = 1; ser_d = 1; tick(); bit_s = 0; ser_d = 0;
    end
    ld_abort = 1; tick(); ld_abort = 0;
    nv++; if (busy !== 1'b0) begin nerr++; $display("FAIL abort_busy got %b want 0", busy); end
    for (int k = 0; k < 8; k++) begin
      bit_s = 1; tick(); bit_s = 0;
      seen |= done;
    end
    nv++; if (seen !== 1'b0) begin nerr++; $display("FAIL abort_done got %b want 0", seen); end
    access(1, 0);
    nv++; if (msel_n !== 4'b1100 || sect !== 4'd3) begin nerr++; $display("FAIL abort_keep got %b/%0d want 1100/3", msel_n, sect); end
  endtask

`ifdef MEMSEL_PARITY_EN
  task automatic test_parity;
    send_frame(2'd1, 4'd7, 2'd1, 1'b0, 1'b1, 1'b0, dc, da, ba);
    nv++; if (dc !== 1'b0 || perr !== 1'b1) begin nerr++; $display("FAIL bad_par got %b/%b want 0/1", dc, perr); end
    access(0, 1);
    nv++; if (msel_n !== 4'b1011 || sect !== 4'd5) begin nerr++; $display("FAIL bad_keep got %b/%0d want 1011/5", msel_n, sect); end
    send_frame(2'd1, 4'd7, 2'd1, 1'b0, 1'b0, 1'b0, dc, da, ba);
    nv++; if (dc !== 1'b1 || perr !== 1'b1) begin nerr++; $display("FAIL good_par got %b/%b want 1/1", dc, perr); end
    access(0, 1);
    nv++; if (msel_n !== 4'b1101 || sect !== 4'd7) begin nerr++; $display("FAIL good_new got %b/%0d want 1101/7", msel_n, sect); end
  endtask
`else
  task automatic test_parity;
    nv++; if (perr !== 1'b0) begin nerr++; $display("FAIL perr_tied got %b want 0", perr); end
  endtask
`endif

  task automatic test_reset_mid;
    ld_i = 1; tick(); ld_i = 0;
    bit_s = 1; ser_d = 1; tick(); tick(); bit_s = 0;
    #2 rst_n = 0;
    #1;
    nv++; if (busy !== 1'b0 || msel_n !== 4'b1111 || perr !== 1'b0) begin nerr++; $display("FAIL async_rst got %b/%b/%b want 0/1111/0", busy, msel_n, perr); end
    tick();
    rst_n = 1;
    tick();
    access(1, 0);
    nv++; if (msel_n !== 4'b1110 || sect !== 4'd0) begin nerr++; $display("FAIL rst_clear got %b/%0d want 1110/0", msel_n, sect); end
  endtask

  initial begin
    test_reset();
    test_data_load();
    test_duplex_conflict();
    test_pending();
    test_commit_collision();
    test_ld_both();
    test_abort();
    test_parity();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
    $finish;
  end
endmodule
